// File: rtl/vsharp_check_pkg.sv
// Shared types for the vsharp result checker: FSM states, default data width
// and the verdict record with its pass rule.
package vsharp_check_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_MAX_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic                 passed;
        logic                 timed_out;
        logic [CNT_MAX_W-1:0] fail_count;
    } verdict_t;

    function automatic logic verdict_pass(input verdict_t v, input logic table_full);
        return (v.fail_count == {CNT_MAX_W{1'b0}}) && !v.timed_out && table_full;
    endfunction

endpackage

// File: rtl/vsharp_exp_table.sv
// Expected-value table: fills in order up to NUM_CHECKS entries (no wrap).
// Entries at or beyond the write pointer read back as zero.
module vsharp_exp_table
    import vsharp_check_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_CHECKS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          clear_i,
    input  logic [$clog2(NUM_CHECKS)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          full_o
);
    localparam int IW = $clog2(NUM_CHECKS);
    localparam int PW = $clog2(NUM_CHECKS + 1);

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [NUM_CHECKS];
    logic              do_wr_s;

    assign full_o    = (ptr_q == PW'(NUM_CHECKS));
    assign do_wr_s   = wr_i && !clear_i && !full_o;
    assign rd_data_o = (PW'(rd_idx_i) < ptr_q) ? mem_q[rd_idx_i] : {DATA_W{1'b0}};

    // Write pointer next state; clear takes priority over a write.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = {PW{1'b0}};
        end else if (do_wr_s) begin
            ptr_d = ptr_q + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Write pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Table storage; contents beyond the pointer are masked on read, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[ptr_q[IW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/vsharp_result_checker.sv
// In-order result checker with per-beat timeout and final verdict.
// Define VSHARP_CHECKER_TRACE_EN to print a per-compare and verdict trace.
module vsharp_result_checker
    import vsharp_check_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            exp_wr,
    input  logic [DATA_W-1:0]               exp_wdata,
    input  logic                            clear,
    input  logic                            start,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [$clog2(NUM_CHECKS+1)-1:0] pass_count,
    output logic [$clog2(NUM_CHECKS+1)-1:0] fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]   first_fail_idx,
    output logic                            done,
    output logic                            timed_out,
    output logic                            passed
);
    localparam int CW = $clog2(NUM_CHECKS + 1);
    localparam int IW = $clog2(NUM_CHECKS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CHECKS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [CW-1:0]     pass_q, pass_d;
    logic [IW-1:0]     ffi_q, ffi_d;
    verdict_t          verdict_q, verdict_d;
    logic [DATA_W-1:0] rd_data_s;
    logic              full_s;
    logic              tab_en_s;

    assign tab_en_s = (state_q == IDLE) || (state_q == DONE);

    vsharp_exp_table #(
        .DATA_W     (DATA_W),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (exp_wr && tab_en_s),
        .wdata_i   (exp_wdata),
        .clear_i   (clear && tab_en_s),
        .rd_idx_i  (idx_q),
        .rd_data_o (rd_data_s),
        .full_o    (full_s)
    );

    // Run-control FSM next state and counter updates.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        ffi_d     = ffi_q;
        verdict_d = verdict_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WAIT;
                    idx_d     = {IW{1'b0}};
                    tmo_d     = {TW{1'b0}};
                    pass_d    = {CW{1'b0}};
                    ffi_d     = {IW{1'b0}};
                    verdict_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = COMPARE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d             = DONE;
                    verdict_d.timed_out = 1'b1;
                    verdict_d.passed    = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            COMPARE: begin
                if (data_q == rd_data_s) begin
                    pass_d = pass_q + CW'(1);
                end else begin
                    verdict_d.fail_count = verdict_q.fail_count + CNT_MAX_W'(1);
                    if (verdict_q.fail_count == {CNT_MAX_W{1'b0}}) begin
                        ffi_d = idx_q;
                    end else begin
                        ffi_d = ffi_q;
                    end
                end
                idx_d = idx_q + IW'(1);
                tmo_d = {TW{1'b0}};
                if (idx_q == IDX_LAST) begin
                    state_d          = DONE;
                    verdict_d.passed = verdict_pass(verdict_d, full_s);
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and run-result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= {DATA_W{1'b0}};
            idx_q     <= {IW{1'b0}};
            tmo_q     <= {TW{1'b0}};
            pass_q    <= {CW{1'b0}};
            ffi_q     <= {IW{1'b0}};
            verdict_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            pass_q    <= pass_d;
            ffi_q     <= ffi_d;
            verdict_q <= verdict_d;
        end
    end

    assign in_ready       = (state_q == WAIT);
    assign done           = (state_q == DONE);
    assign pass_count     = pass_q;
    assign fail_count     = verdict_q.fail_count[CW-1:0];
    assign first_fail_idx = ffi_q;
    assign timed_out      = verdict_q.timed_out;
    assign passed         = verdict_q.passed;

`ifdef VSHARP_CHECKER_TRACE_EN
    // Simulation trace of each comparison and of the final verdict.
    always_ff @(posedge clk) begin
        if (!reset && state_q == COMPARE) begin
            $display("[vsharp] idx %0d got %h exp %h %s", idx_q, data_q, rd_data_s,
                     (data_q == rd_data_s) ? "PASS" : "FAIL");
        end
        if (!reset && state_q != DONE && state_d == DONE) begin
            $display("[vsharp] verdict passed=%0b timed_out=%0b fails=%0d",
                     verdict_d.passed, verdict_d.timed_out, verdict_d.fail_count);
        end
    end
`else
    // Trace disabled: the checker produces no simulation output.
`endif

endmodule

// File: tb/tb_vsharp_result_checker.sv
// Self-checking bench for vsharp_result_checker: directed vector table,
// hand-written latency/rerun/reset sequences and randomized runs against a model.
module tb_vsharp_result_checker;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int T  = 16;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset, exp_wr, clear, start, in_valid;
    logic [DW-1:0] exp_wdata, in_data;
    logic          in_ready, done, timed_out, passed;
    logic [CW-1:0] pass_count, fail_count;
    logic [IW-1:0] first_fail_idx;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mtab[$];

    typedef struct {
        int              nld;
        logic [4:0][31:0] ld;   // element 0 is the rightmost word
        logic [3:0][31:0] rx;
        logic [3:0][7:0]  gap;
        int              ep, ef, effi;
        bit              eto, eps;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    vsharp_result_checker #(.DATA_W(DW), .NUM_CHECKS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .exp_wr(exp_wr), .exp_wdata(exp_wdata), .clear(clear),
        .start(start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pass_count(pass_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .done(done), .timed_out(timed_out), .passed(passed)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Clear (with a simultaneous junk write that must lose), then load n words.
    task automatic load_table(input int n, input logic [4:0][31:0] ld);
        @(negedge clk);
        clear = 1'b1; exp_wr = 1'b1; exp_wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        clear = 1'b0;
        mtab.delete();
        for (int i = 0; i < n; i++) begin
            exp_wr = 1'b1; exp_wdata = ld[i];
            @(negedge clk);
            if (mtab.size() < N) mtab.push_back(ld[i]);
        end
        exp_wr = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Hold in_valid low for 'gap' WAIT cycles, then present the beat.
    task automatic send_beat(input logic [31:0] d, input int gap);
        int idle = 0;
        in_valid = 1'b0;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (done) return;
            if (in_ready) begin
                if (idle < gap) begin
                    idle++;
                end else begin
                    in_valid = 1'b1; in_data = d;
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                    return;
                end
            end
        end
        n_tests++; n_fail++;
        $display("FAIL beat_wait: in_ready never seen within 64 cycles");
    endtask

    task automatic run(input logic [3:0][31:0] rx, input logic [3:0][7:0] gap);
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat(rx[i], int'(gap[i]));
        for (int w = 0; w < 40 && !done; w++) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int ep, input int ef, input int effi,
                                input bit eto, input bit eps);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".pass"}, pass_count, ep);
        chk({tag, ".fail"}, fail_count, ef);
        if (ef != 0) chk({tag, ".ffi"}, first_fail_idx, effi);
        chk({tag, ".tout"}, timed_out, eto);
        chk({tag, ".passed"}, passed, eps);
    endtask

    // Reference: walk beats in order against the loaded list (short table reads 0).
    task automatic model(input logic [3:0][31:0] rx, input logic [3:0][7:0] gap,
                         output int p, output int f, output int ffi, output bit to, output bit ps);
        logic [31:0] ev;
        p = 0; f = 0; ffi = 0; to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(gap[i]) >= T) begin
                to = 1'b1;
                break;
            end
            ev = (i < mtab.size()) ? mtab[i] : 32'd0;
            if (rx[i] == ev) p++;
            else begin
                if (f == 0) ffi = i;
                f++;
            end
        end
        ps = !to && (f == 0) && (mtab.size() == N);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p, f, ffi;
        bit to, ps;
        logic [4:0][31:0] ld;
        logic [3:0][31:0] rx;
        logic [3:0][7:0]  gap;

        vecs[0] = '{nld:4, ld:{32'd0,32'd4,32'd3,32'd2,32'd1}, rx:{32'd4,32'd3,32'd2,32'd1},
                    gap:32'd0, ep:4, ef:0, effi:0, eto:1'b0, eps:1'b1};
        vecs[1] = '{nld:4, ld:{32'd0,32'd4,32'd3,32'd2,32'd1}, rx:{32'd7,32'd3,32'd9,32'd1},
                    gap:32'd0, ep:2, ef:2, effi:1, eto:1'b0, eps:1'b0};
        vecs[2] = '{nld:4, ld:{32'd0,32'd4,32'd3,32'd2,32'd1}, rx:{32'd4,32'd3,32'd2,32'd1},
                    gap:{8'd0,8'd20,8'd0,8'd0}, ep:2, ef:0, effi:0, eto:1'b1, eps:1'b0};
        vecs[3] = '{nld:2, ld:{32'd0,32'd0,32'd0,32'd2,32'd1}, rx:{32'd0,32'd0,32'd0,32'd0},
                    gap:32'd0, ep:2, ef:2, effi:0, eto:1'b0, eps:1'b0};
        vecs[4] = '{nld:5, ld:{32'd5,32'd4,32'd3,32'd2,32'd1}, rx:{32'd4,32'd3,32'd2,32'd1},
                    gap:{8'd3,8'd0,8'd14,8'd1}, ep:4, ef:0, effi:0, eto:1'b0, eps:1'b1};
        vecs[5] = '{nld:4, ld:{32'd0,32'h8000_0000,32'hFFFF_FFFF,32'd0,32'hDEAD_BEEF},
                    rx:{32'h8000_0001,32'hFFFF_FFFF,32'd0,32'hDEAD_BEEF},
                    gap:32'd0, ep:3, ef:1, effi:3, eto:1'b0, eps:1'b0};

        reset = 1'b1; exp_wr = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        exp_wdata = '0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.pass", pass_count, 0);
        chk("rst.fail", fail_count, 0);
        chk("rst.ffi", first_fail_idx, 0);
        chk("rst.done", done, 0);
        chk("rst.tout", timed_out, 0);
        chk("rst.passed", passed, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_table(vecs[v].nld, vecs[v].ld);
            run(vecs[v].rx, vecs[v].gap);
            check_result($sformatf("vec%0d", v), vecs[v].ep, vecs[v].ef, vecs[v].effi,
                         vecs[v].eto, vecs[v].eps);
        end

        // Rerun from DONE without reloading; check clearing, in_ready rise and latency.
        pulse_start();
        chk("rerun.in_ready", in_ready, 1);
        chk("rerun.pass0", pass_count, 0);
        chk("rerun.fail0", fail_count, 0);
        chk("rerun.done0", done, 0);
        send_beat(32'h8000_0000 ^ 32'h5EAD_BEEF ^ 32'h5EAD_BEEF ^ 32'h8000_0000 ^ 32'hDEAD_BEEF, 0);
        chk("lat.pass_at_accept", pass_count, 0);
        @(negedge clk);
        chk("lat.in_ready_cmp", in_ready, 0);
        chk("lat.pass_in_cmp", pass_count, 0);
        @(negedge clk);
        chk("lat.pass_after", pass_count, 1);
        chk("lat.in_ready_back", in_ready, 1);
        send_beat(32'd0, 0);
        send_beat(32'hFFFF_FFFF, 0);
        send_beat(32'h8000_0000, 0);
        @(negedge clk);
        chk("lat.done_in_cmp", done, 0);
        @(negedge clk);
        chk("lat.done", done, 1);
        chk("lat.pass4", pass_count, 4);
        chk("lat.passed", passed, 1);

        // Reset mid-run clears outputs and the table pointer.
        ld = {32'd0, 32'd4, 32'd3, 32'd2, 32'd1};
        load_table(4, ld);
        pulse_start();
        send_beat(32'd1, 0);
        send_beat(32'd2, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid.in_ready", in_ready, 0);
        chk("mid.pass", pass_count, 0);
        chk("mid.fail", fail_count, 0);
        chk("mid.done", done, 0);
        chk("mid.tout", timed_out, 0);
        chk("mid.passed", passed, 0);
        @(negedge clk);
        reset = 1'b0;
        mtab.delete();
        exp_wr = 1'b1; exp_wdata = 32'd7;
        @(negedge clk);
        exp_wr = 1'b0;
        mtab.push_back(32'd7);
        rx = {32'd0, 32'd0, 32'd0, 32'd7};
        run(rx, 32'd0);
        check_result("mid.rerun", 4, 0, 0, 1'b0, 1'b0);

        // Randomized runs against the reference model.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int i = 0; i < 5; i++) ld[i] = $urandom;
            load_table(n, ld);
            for (int i = 0; i < 4; i++) begin
                rx[i]  = ($urandom_range(0, 3) != 0) ? ((i < mtab.size()) ? mtab[i] : 32'd0) : $urandom;
                gap[i] = 8'($urandom_range(0, 8));
            end
            if ($urandom_range(0, 5) == 0) gap[$urandom_range(0, 3)] = 8'd20;
            run(rx, gap);
            model(rx, gap, p, f, ffi, to, ps);
            check_result($sformatf("rnd%0d", it), p, f, ffi, to, ps);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vsharp_result_checker.md
# vsharp_result_checker

Self-checking consumer for the 32-bit result stream produced by compiler-generated FSM modules under test. It captures results over a valid/ready handshake and compares them in order against a preloaded table of expected values. It counts passes and failures, enforces a per-result timeout, and reports a final verdict. It sits in unit-test benches, downstream of the generated module's output register.

## Interface
Parameters:
- DATA_W, 32, width of result and expected words
- NUM_CHECKS, 4, number of results to check, which is also the expected-table depth (power of two, ≥2)
- TIMEOUT_CYCLES, 16, maximum idle cycles allowed in WAIT before a timeout

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- exp_wr  input  1  write the next expected value into the table
- exp_wdata  input  DATA_W  expected value to write
- clear  input  1  empty the expected table (write pointer to 0)
- start  input  1  single-cycle pulse that begins a check run
- in_data  input  DATA_W  result word from the unit under test
- in_valid  input  1  in_data is valid
- in_ready  output  1  checker accepts a beat this cycle
- pass_count  output  $clog2(NUM_CHECKS+1)  matching results so far
- fail_count  output  $clog2(NUM_CHECKS+1)  mismatching results so far
- first_fail_idx  output  $clog2(NUM_CHECKS)  index of the first mismatch (valid when fail_count≠0)
- done  output  1  run finished (level)
- timed_out  output  1  run ended by timeout (level)
- passed  output  1  verdict; meaningful only when done=1

## Operation
- FSM states: IDLE, WAIT, COMPARE, DONE.
- IDLE:
  - exp_wr stores exp_wdata at the write pointer, then the pointer increments.
  - Writes are ignored once the pointer reaches NUM_CHECKS (table full, no wrap).
  - clear resets the pointer. If clear and exp_wr are asserted together, clear wins.
  - start moves the FSM to WAIT and zeroes the counters, the check index, timed_out and the timeout counter.
- WAIT:
  - in_ready=1.
  - A beat (in_valid && in_ready) latches in_data and moves to COMPARE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES-1 without a beat, the FSM moves to DONE with timed_out=1.
- COMPARE:
  - in_ready=0.
  - The latched word is compared with table[check index]. A match increments pass_count; a mismatch increments fail_count and, if this is the first failure, records first_fail_idx.
  - The check index increments and the timeout counter clears.
  - If the check index was NUM_CHECKS-1, go to DONE; otherwise go to WAIT.
- DONE:
  - done=1.
  - passed = (fail_count==0) && !timed_out && (table holds NUM_CHECKS entries).
  - start re-runs the check: go to WAIT, keep the table, clear the counters.
- exp_wr and clear are ignored outside IDLE and DONE. start is ignored in WAIT and COMPARE.
- Comparison is an exact DATA_W-bit equality. Counters cannot overflow because the check index bounds them.
- A run started with a partially loaded table still compares against every index, so unwritten entries read as 0. passed is forced to 0 in that case.

## Timing
- Reset values: in_ready=0, pass_count=0, fail_count=0, first_fail_idx=0, done=0, timed_out=0, passed=0, state=IDLE, write pointer=0.
- All outputs are registered or decoded directly from state.
- in_ready rises the cycle after start.
- Counter update latency: one cycle after the accepting edge.
- Maximum throughput: one beat every 2 cycles.
- done asserts one cycle after the final COMPARE.
- Reset asserted mid-run aborts immediately and also clears the table pointer.

## Configuration
- Macro: VSHARP_CHECKER_TRACE_EN.
- Defined: each COMPARE prints `$display` with the index, the received value and the expected value in hex, plus PASS or FAIL. Entering DONE prints the verdict.
- Undefined: no simulation output.
- Synthesized logic is identical either way.

## Structure
- Package vsharp_check_pkg holds:
  - the state enum (IDLE, WAIT, COMPARE, DONE);
  - the DATA_W default constant;
  - a verdict struct {passed, timed_out, fail_count}.
- Sub-module vsharp_exp_table holds the expected-value table: write pointer, full flag, combinational read port indexed by the check index.

## Test plan
- Load {1,2,3,4}, start, send 1,2,3,4 with in_valid held high → pass_count=4, fail_count=0, done=1, passed=1.
- Load {1,2,3,4}, send 1,9,3,7 → fail_count=2, first_fail_idx=1, passed=0.
- Load 4 values, send 2 beats, then hold in_valid low for 16 cycles → timed_out=1, done=1, passed=0, pass_count=2.
- Load 2 values only, send 4 zero words → pass_count=2 (indices 2–3 match 0), passed=0 (table short).
- Assert reset mid-run after 2 beats → all outputs 0, state IDLE, a 5th exp_wr stores into entry 0.
- Write 5 values → the 5th is ignored. Pulse start in DONE → counters clear, rerun with 1,2,3,4 gives passed=1.
